// File: rtl/aes_decrypt_iter_if.sv
// aes_decrypt_iter_if: block-in / block-out valid-ready bundle.
// master drives ciphertext+key and out_ready; slave is the core.
interface aes_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decryption, one inverse round/clk.
// Ports: clk, rst_n (async low), bus (slave: ciphertext+K10 in, plaintext
// out, valid/ready both sides), busy (ROUND or DONE).
// Option: AES_DEC_BACK2BACK_EN lets DONE accept the next block directly.
module aes_decrypt_iter (
  input  logic              clk,
  input  logic              rst_n,
  aes_decrypt_iter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] od_q, od_d;
  logic         ov_q, ov_d;
  logic         in_rdy;
  logic [127:0] key_prev;
  logic [127:0] ark;
  logic [127:0] rnd_res;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] p;
    sq = a;
    p  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      p  = gmul(p, sq);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]}
              ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd10:   v = 8'h36;
      4'd9:    v = 8'h1b;
      4'd8:    v = 8'h80;
      4'd7:    v = 8'h40;
      4'd6:    v = 8'h20;
      4'd5:    v = 8'h10;
      4'd4:    v = 8'h08;
      4'd3:    v = 8'h04;
      4'd2:    v = 8'h02;
      4'd1:    v = 8'h01;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Byte i of a block, FIPS-197 order (byte 0 in the top bits).
  function automatic logic [7:0] bget(
    input logic [127:0] v,
    input int           i
  );
    return v[127-8*i -: 8];
  endfunction

  // Row r is rotated right by r: out(r,c) = in(r,c-r).
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = bget(s, r + 4*((c - r + 4) % 4));
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(bget(s, i));
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = bget(s, 4*c);
      a1 = bget(s, 4*c + 1);
      a2 = bget(s, 4*c + 2);
      a3 = bget(s, 4*c + 3);
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Undo one forward expansion step: K_r -> K_(r-1).
  function automatic logic [127:0] inv_key(
    input logic [127:0] k,
    input logic [3:0]   r
  );
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rw, sw;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    rw = {w3[23:0], w3[31:24]};
    sw = {sbox(rw[31:24]), sbox(rw[23:16]),
          sbox(rw[15:8]),  sbox(rw[7:0])};
    w0 = w0 ^ sw ^ {rcon(r), 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    key_prev = inv_key(key_q, rnd_q);
    ark      = inv_sub(inv_shift(st_q)) ^ key_prev;
    rnd_res  = (rnd_q == 4'd1) ? ark : inv_mix(ark);
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    ov_d    = ov_q;
    od_d    = od_q;
    in_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          st_d    = bus.in_data ^ bus.in_key;
          key_d   = bus.in_key;
          rnd_d   = 4'd10;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d  = rnd_res;
        key_d = key_prev;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          state_d = DONE;
          ov_d    = 1'b1;
          od_d    = rnd_res;
        end
      end
      DONE: begin
`ifdef AES_DEC_BACK2BACK_EN
        in_rdy = bus.out_ready;
`endif
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
`ifdef AES_DEC_BACK2BACK_EN
          if (bus.in_valid) begin
            st_d    = bus.in_data ^ bus.in_key;
            key_d   = bus.in_key;
            rnd_d   = 4'd10;
            state_d = ROUND;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      key_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter: directed FIPS-197 vectors, backpressure,
// input noise while busy, mid-block reset and streaming period.
module tb_aes_decrypt_iter;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_DEC_BACK2BACK_EN
  localparam int  PERIOD   = 11;
  localparam logic RDY_DONE = 1'b1;
`else
  localparam int  PERIOD   = 12;
  localparam logic RDY_DONE = 1'b0;
`endif

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    bit           garb;
  } vec_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_cmp;
  int   n_err;

  aes_decrypt_iter_if bus ();

  aes_decrypt_iter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one block, wait for accept, then count cycles to out_valid.
  // Entered and left at #1 after a rising edge.
  task automatic run_block(
    input  logic [127:0] ct,
    input  logic [127:0] k,
    input  bit           garb,
    output int           lat,
    output logic [127:0] got
  );
    int n;
    bus.in_data  = ct;
    bus.in_key   = k;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    got = '0;
    for (int c = 1; c <= 20; c++) begin
      if (garb && c <= 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        got = bus.out_data;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t         tv [4];
    int           lat;
    logic [127:0] got;
    int           nout;
    int           idx;
    int           last_acc;
    bit           acc;
    bit           hs;
    logic [127:0] od;

    tv[0] = '{C1_CT, C1_K, C1_PT, 1'b0};
    tv[1] = '{B_CT,  B_K,  B_PT,  1'b0};
    tv[2] = '{C1_CT, C1_K, C1_PT, 1'b1};
    tv[3] = '{B_CT,  B_K,  B_PT,  1'b1};

    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_busy", 128'(busy), 128'(1'b0));

    // Table: plain and noisy-input blocks, out_ready high.
    for (int i = 0; i < 4; i++) begin
      run_block(tv[i].ct, tv[i].key, tv[i].garb, lat, got);
      check("tbl_data", got, tv[i].pt);
      check("tbl_latency", 128'(lat), 128'(10));
      check("tbl_busy_done", 128'(busy), 128'(1'b1));
      check("tbl_rdy_done", 128'(bus.in_ready), 128'(RDY_DONE));
      @(posedge clk);
      #1;
      check("tbl_ov_after", 128'(bus.out_valid), 128'(1'b0));
      check("tbl_rdy_after", 128'(bus.in_ready), 128'(1'b1));
      check("tbl_busy_after", 128'(busy), 128'(1'b0));
    end

    // Backpressure: hold plaintext for 5 cycles.
    bus.out_ready = 1'b0;
    run_block(C1_CT, C1_K, 1'b0, lat, got);
    check("bp_data", got, C1_PT);
    check("bp_latency", 128'(lat), 128'(10));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_ov", 128'(bus.out_valid), 128'(1'b1));
      check("bp_hold_data", bus.out_data, C1_PT);
      check("bp_hold_rdy", 128'(bus.in_ready), 128'(1'b0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_ov", 128'(bus.out_valid), 128'(1'b0));
    check("bp_rel_rdy", 128'(bus.in_ready), 128'(1'b1));
    check("bp_rel_busy", 128'(busy), 128'(1'b0));

    // Reset after E5 of a block.
    bus.in_data  = C1_CT;
    bus.in_key   = C1_K;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_pre", 128'(busy), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 128'(bus.out_valid), 128'(1'b0));
    check("mid_rst_data", bus.out_data, '0);
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_rdy", 128'(bus.in_ready), 128'(1'b1));
    check("mid_rel_ov", 128'(bus.out_valid), 128'(1'b0));
    run_block(B_CT, B_K, 1'b0, lat, got);
    check("mid_after_data", got, B_PT);
    check("mid_after_lat", 128'(lat), 128'(10));
    @(posedge clk);
    #1;

    // Streaming with in_valid held high, alternating vectors.
    bus.out_ready = 1'b1;
    idx      = 0;
    nout     = 0;
    last_acc = 0;
    bus.in_data  = tv[0].ct;
    bus.in_key   = tv[0].key;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && nout < 4; cyc++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      od  = bus.out_data;
      @(posedge clk);
      #1;
      if (acc) begin
        if (idx > 0)
          check("stream_period", 128'(cyc - last_acc), 128'(PERIOD));
        last_acc = cyc;
        idx++;
        if (idx < 4) begin
          bus.in_data = tv[idx % 2].ct;
          bus.in_key  = tv[idx % 2].key;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (hs) begin
        check("stream_data", od, tv[nout % 2].pt);
        nout++;
      end
    end
    bus.in_valid = 1'b0;
    if (nout < 4) check("stream_timeout", 128'(nout), 128'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
Iterative AES-128 decryption core. It is the inverse-direction counterpart of the encryption round datapath.
- Accepts one 128-bit ciphertext block plus the final (round-10) expanded key over a valid/ready handshake.
- Runs 10 inverse rounds, one per clock, deriving earlier round keys on the fly by inverse key expansion.
- Presents the plaintext on a valid/ready output port. Sits between the key/ciphertext source and the downstream consumer.

Parameters:
None. AES-128 only, fixed 10 rounds.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext and key present
in_ready  output  1  core can accept a block
in_data  input  128  ciphertext; byte 0 = [127:120], FIPS-197 column-major order
in_key  input  128  round-10 key K10, same byte order
out_valid  output  1  plaintext valid
out_ready  input  1  consumer accepts plaintext
out_data  output  128  plaintext
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; round counter=0; state and key registers=0.
  - in_ready=1 after release; out_valid=0; out_data=0; busy=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready edge (E0): state_reg<=in_data^in_key; key_reg<=in_key; rnd<=10; go ROUND.
- ROUND (edges E1..E10):
  - Inverse key step K_rnd -> K_(rnd-1), with words w0..w3:
    - w3'=w3^w2; w2'=w2^w1; w1'=w1^w0.
    - w0'=w0^SubWord(RotWord(w3'))^Rcon(rnd).
    - Rcon for rnd=10..1: 36,1b,80,40,20,10,08,04,02,01 in the top byte.
  - Datapath: state_reg<=InvMixColumns(InvSubBytes(InvShiftRows(state_reg))^K_(rnd-1)).
    - InvMixColumns is omitted when rnd==1 (final round).
  - key_reg<=K_(rnd-1); rnd<=rnd-1.
  - At rnd==1: go DONE; out_valid<=1; out_data<=result.
- DONE:
  - out_data is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid<=0; go IDLE.
- Latency: 10 cycles from the accept edge to out_valid high. Block period is 12 cycles with out_ready tied high.
- in_ready=0 in ROUND and DONE (unless the optional feature is enabled). in_data and in_key are ignored then, and need only be stable on the accept edge.
- Key register is internal; K10 must be re-supplied with every block.
- Reset mid-operation aborts the block immediately: no partial out_valid, returns to IDLE.
- Arithmetic: all GF(2^8) with polynomial 0x11B.
  - InvMixColumns coefficients 0e,0b,0d,09.
  - S-boxes are pure combinational lookups, with no extra pipeline stage.

Optional Feature:
Macro AES_DEC_BACK2BACK_EN.
- Defined:
  - in DONE, in_ready=out_ready.
  - A simultaneous output handshake and in_valid loads the new block directly, exactly as the IDLE accept, and goes to ROUND.
  - Period becomes 11 cycles.
- Undefined:
  - in_ready high only in IDLE.
  - An in_valid asserted during DONE waits until the cycle after the output handshake.

Test Plan:
- FIPS-197 C.1: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, in_key=13111d7fe3944a17f307a78b4d2b30c5 -> out_data=00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: in_data=3925841d02dc09fbdc118597196a0b32, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> out_data=3243f6a8885a308d313198a2e0370734.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout; out_ready=1 -> next cycle IDLE, in_ready=1.
- Input toggled while busy: in_valid=1 with garbage in_data during ROUND -> ignored; C.1 result unchanged.
- Reset at E5 of a block: rst_n low mid-round -> out_valid=0, out_data=0 immediately; after release a fresh App. B block decrypts correctly.
- Streaming, out_ready=1, in_valid=1 continuous with alternating C.1/App. B vectors -> correct results, period 12 cycles (11 with AES_DEC_BACK2BACK_EN).
